config_reg_chip_emulator: RTL and testbench
===========================================

// Module: config_reg_chip_emulator
// PURPOSE
//  FPGA-side emulator of the chip's serial configuration shift register: the far end of the
//  SuperpixSel/ConfigClk/Reset_not/ConfigIn/ConfigLoad/ConfigOut link driven by the AXI config
//  writer. Oversamples the link on S_AXI_ACLK, shifts in ConfigIn, latches ParallelOut on
//  ConfigLoad and drives ConfigOut back. Used for loopback bring-up and as a chip stand-in.
// PARAMETERS
//  CONFIG_REG_WIDTH  5164  shift-register / ParallelOut width (>=2)
//  SYNC_STAGES       2     synchroniser depth on all link inputs (>=2)
//  CNT_WIDTH         16    width of shifted-bit counters
// PORTS
//  S_AXI_ACLK      in   1     sole clock; all logic on its rising edge
//  S_AXI_ARESETN   in   1     asynchronous, active-low reset
//  ConfigClk       in   1     link shift clock, asynchronous to S_AXI_ACLK
//  Reset_not       in   1     link reset, active low, asynchronous
//  ConfigIn        in   1     link serial data
//  ConfigLoad      in   1     link load strobe, asynchronous
//  SuperpixSel     in   1     link superpixel select, asynchronous
//  ConfigOut       out  1     serial data back to writer = MSB of shift register
//  ParallelOut     out  W     latched register image (W = CONFIG_REG_WIDTH)
//  load_pulse      out  1     one-cycle strobe when ParallelOut updates
//  superpix_sel_q  out  1     synchronised SuperpixSel
//  bit_count       out  CW    ConfigClk rising edges since last load/reset (saturating)
//  last_count      out  CW    bit_count value captured at last load
//  overflow        out  1     sticky: more than W bits shifted since last load/reset
// BEHAVIOUR
//  Reset (S_AXI_ARESETN=0, async): sr, ParallelOut, bit_count, last_count = 0; ConfigOut,
//   load_pulse, overflow, superpix_sel_q = 0; synchroniser flops = 0 (so first high of
//   ConfigClk/ConfigLoad after reset counts as a rising edge).
//  Inputs: each passes SYNC_STAGES flops; one extra flop on clk_s, load_s for edge detect.
//   clk_rise = clk_s & ~clk_d; load_rise = load_s & ~load_d. in_s sampled in same cycle.
//  Shift (clk_rise, link not in reset): sr <= {sr[W-2:0], in_s}; bit_count <= bit_count+1,
//   saturating at 2^CW-1; overflow <= 1 when bit_count (pre-increment) >= W.
//  ConfigOut: registered copy of sr[W-1]; valid 1 cycle after the shift.
//  Latency: ConfigClk rise -> sr update = SYNC_STAGES+1 cycles; ConfigOut = +1 more.
//  Load (load_rise, link not in reset): ParallelOut <= sr_next (includes shift of same
//   cycle if clk_rise coincides); last_count <= bit_count_next; bit_count <= 0;
//   overflow <= 0; load_pulse = 1 for exactly one cycle. Level-high ConfigLoad = one load.
//  Link reset (synchronised Reset_not=0): sr, ParallelOut, bit_count, last_count, overflow
//   cleared every cycle while low; clk_rise/load_rise ignored; ConfigOut=0 next cycle.
//   Mid-shift assertion discards partial data; no load_pulse.
//  ConfigClk/ConfigLoad high or low pulses shorter than SYNC_STAGES+1 ACLK cycles are
//   unsupported (writer CLK_DIVIDER guarantees >= 50 cycles per half period).
//  No state machine beyond edge detect; superpix_sel_q is purely synchronised, no latch.
// TESTING
//  1 W=8: shift 0xA5 MSB-first, pulse ConfigLoad -> ParallelOut=0xA5, load_pulse 1 cycle,
//    last_count=8, overflow=0, bit_count=0.
//  2 W=8: shift 10 bits 1,1,0..0 then load -> ParallelOut=0x00, overflow=1 before load,
//    0 after, last_count=10; ConfigOut replays first bit after 8 shifts.
//  3 Loopback: writer with CLK_DIVIDER=4 sends 5164-bit pattern twice -> second pass
//    ConfigOut stream equals first pattern bit-for-bit, ParallelOut = pattern.
//  4 ConfigClk rise and ConfigLoad rise in same ACLK cycle after 7 bits (W=8) ->
//    ParallelOut includes 8th bit, last_count=8.
//  5 Reset_not low after 4 of 8 bits, release, shift 0x3C, load -> ParallelOut=0x3C,
//    no load_pulse during link reset.
//  6 S_AXI_ARESETN asserted mid-shift -> all outputs 0 asynchronously; next 8 bits + load
//    -> correct value.

Source files
------------

// File: rtl/config_reg_chip_emulator.sv
// config_reg_chip_emulator
//   FPGA-side stand-in for the chip's serial configuration shift register. The link from the
//   AXI config writer is oversampled on S_AXI_ACLK. ConfigIn is shifted in on each ConfigClk
//   rise, ParallelOut is latched on each ConfigLoad rise, and ConfigOut returns the register MSB.
//
// Ports
//   S_AXI_ACLK     in   sole clock, rising edge
//   S_AXI_ARESETN  in   asynchronous active-low reset
//   ConfigClk      in   link shift clock (asynchronous)
//   Reset_not      in   link reset, active low (asynchronous)
//   ConfigIn       in   link serial data
//   ConfigLoad     in   link load strobe (asynchronous)
//   SuperpixSel    in   link superpixel select (asynchronous)
//   ConfigOut      out  registered MSB of the shift register
//   ParallelOut    out  latched register image
//   load_pulse     out  one-cycle strobe when ParallelOut updates
//   superpix_sel_q out  synchronised SuperpixSel
//   bit_count      out  saturating count of shifts since last load/reset
//   last_count     out  bit_count captured at last load
//   overflow       out  sticky: more than CONFIG_REG_WIDTH bits shifted since last load/reset

module config_reg_chip_emulator #(
    parameter int unsigned CONFIG_REG_WIDTH = 5164,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    input  logic                        ConfigClk,
    input  logic                        Reset_not,
    input  logic                        ConfigIn,
    input  logic                        ConfigLoad,
    input  logic                        SuperpixSel,
    output logic                        ConfigOut,
    output logic [CONFIG_REG_WIDTH-1:0] ParallelOut,
    output logic                        load_pulse,
    output logic                        superpix_sel_q,
    output logic [CNT_WIDTH-1:0]        bit_count,
    output logic [CNT_WIDTH-1:0]        last_count,
    output logic                        overflow
);

    localparam int unsigned W = CONFIG_REG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    // Link bit positions inside the synchroniser vector
    localparam int unsigned LnkClk  = 0;
    localparam int unsigned LnkRst  = 1;
    localparam int unsigned LnkIn   = 2;
    localparam int unsigned LnkLoad = 3;
    localparam int unsigned LnkSel  = 4;

    logic [4:0]           w_link_in;
    logic [4:0]           r_sync [SYNC_STAGES];
    logic [4:0]           w_sync_out;
    logic                 r_clk_d;
    logic                 r_load_d;
    logic                 w_clk_rise;
    logic                 w_load_rise;
    logic                 w_link_rst;
    logic                 w_shift;
    logic                 w_load;

    logic [W-1:0]         r_sr;
    logic [W-1:0]         w_sr_next;
    logic [W-1:0]         r_parallel;
    logic [CNT_WIDTH-1:0] r_bit_count;
    logic [CNT_WIDTH-1:0] w_bit_count_next;
    logic [CNT_WIDTH-1:0] r_last_count;
    logic                 r_overflow;
    logic                 w_overflow_next;
    logic                 r_config_out;
    logic                 r_load_pulse;

    assign w_link_in = {SuperpixSel, ConfigLoad, ConfigIn, Reset_not, ConfigClk};

    // Synchronisers clear to 0, so a link line already high at reset release looks like a rise.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
            r_clk_d  <= 1'b0;
            r_load_d <= 1'b0;
        end else begin
            r_sync[0] <= w_link_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_clk_d  <= w_sync_out[LnkClk];
            r_load_d <= w_sync_out[LnkLoad];
        end
    end

    assign w_sync_out  = r_sync[SYNC_STAGES-1];
    assign w_clk_rise  = w_sync_out[LnkClk] & ~r_clk_d;
    assign w_load_rise = w_sync_out[LnkLoad] & ~r_load_d;
    assign w_link_rst  = ~w_sync_out[LnkRst];
    assign w_shift     = w_clk_rise & ~w_link_rst;
    assign w_load      = w_load_rise & ~w_link_rst;

    always_comb begin
        w_sr_next        = r_sr;
        w_bit_count_next = r_bit_count;
        w_overflow_next  = r_overflow;
        if (w_shift) begin
            w_sr_next = {r_sr[W-2:0], w_sync_out[LnkIn]};
            if (r_bit_count != CntMax) begin
                w_bit_count_next = r_bit_count + CntOne;
            end
            // Pre-increment count already at W means this shift pushes a bit off the end
            if (32'(r_bit_count) >= W) begin
                w_overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_sr         <= '0;
            r_parallel   <= '0;
            r_bit_count  <= '0;
            r_last_count <= '0;
            r_overflow   <= 1'b0;
            r_config_out <= 1'b0;
            r_load_pulse <= 1'b0;
        end else if (w_link_rst) begin
            r_sr         <= '0;
            r_parallel   <= '0;
            r_bit_count  <= '0;
            r_last_count <= '0;
            r_overflow   <= 1'b0;
            r_config_out <= 1'b0;
            r_load_pulse <= 1'b0;
        end else begin
            r_sr         <= w_sr_next;
            r_config_out <= r_sr[W-1];
            r_load_pulse <= w_load;
            if (w_load) begin
                // A coincident shift is included in the latched image and count
                r_parallel   <= w_sr_next;
                r_last_count <= w_bit_count_next;
                r_bit_count  <= '0;
                r_overflow   <= 1'b0;
            end else begin
                r_bit_count  <= w_bit_count_next;
                r_overflow   <= w_overflow_next;
            end
        end
    end

    assign ConfigOut      = r_config_out;
    assign ParallelOut    = r_parallel;
    assign load_pulse     = r_load_pulse;
    assign superpix_sel_q = w_sync_out[LnkSel];
    assign bit_count      = r_bit_count;
    assign last_count     = r_last_count;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_config_reg_chip_emulator.sv
// tb_config_reg_chip_emulator
//   Drives the serial link slowly relative to S_AXI_ACLK and compares the DUT against a
//   transaction-level model (shift value, count, sticky overflow, latched image).

module tb_config_reg_chip_emulator;

    localparam int unsigned W    = 8;
    localparam int unsigned SS   = 2;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;
    localparam int          HALF = 6;

    logic          clk;
    logic          aresetn;
    logic          cfg_clk;
    logic          rst_not;
    logic          cfg_in;
    logic          cfg_load;
    logic          sp_sel;
    logic          cfg_out;
    logic [W-1:0]  par_out;
    logic          load_pulse;
    logic          sp_sel_q;
    logic [CW-1:0] bit_count;
    logic [CW-1:0] last_count;
    logic          overflow;

    config_reg_chip_emulator #(
        .CONFIG_REG_WIDTH(W),
        .SYNC_STAGES     (SS),
        .CNT_WIDTH       (CW)
    ) u_dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (aresetn),
        .ConfigClk     (cfg_clk),
        .Reset_not     (rst_not),
        .ConfigIn      (cfg_in),
        .ConfigLoad    (cfg_load),
        .SuperpixSel   (sp_sel),
        .ConfigOut     (cfg_out),
        .ParallelOut   (par_out),
        .load_pulse    (load_pulse),
        .superpix_sel_q(sp_sel_q),
        .bit_count     (bit_count),
        .last_count    (last_count),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    // Count cycles in which load_pulse is high, sampled just after each edge
    always @(posedge clk) begin
        #1;
        if (load_pulse === 1'b1) n_pulses++;
    end

    // Reference model
    int m_sr, m_po, m_cnt, m_last, m_ovf;

    task automatic model_clear();
        m_sr = 0; m_po = 0; m_cnt = 0; m_last = 0; m_ovf = 0;
    endtask

    task automatic model_shift(input bit b);
        if (m_cnt >= int'(W)) m_ovf = 1;
        m_sr = ((m_sr << 1) | int'(b)) & ((1 << W) - 1);
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
    endtask

    task automatic model_load();
        m_po = m_sr; m_last = m_cnt; m_cnt = 0; m_ovf = 0;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "/cfg_out"},  32'(cfg_out),    32'((m_sr >> (W - 1)) & 1));
        check_eq({tag, "/par_out"},  32'(par_out),    32'(m_po));
        check_eq({tag, "/bit_cnt"},  32'(bit_count),  32'(m_cnt));
        check_eq({tag, "/last_cnt"}, 32'(last_count), 32'(m_last));
        check_eq({tag, "/overflow"}, 32'(overflow),   32'(m_ovf));
    endtask

    task automatic send_bit(input bit b);
        cfg_in  = b;
        cfg_clk = 1'b0;
        wait_cyc(HALF);
        cfg_clk = 1'b1;
        wait_cyc(HALF);
        model_shift(b);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        cfg_clk = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic do_load(input string tag);
        int p0;
        p0 = n_pulses;
        cfg_load = 1'b1;
        wait_cyc(HALF);
        cfg_load = 1'b0;
        wait_cyc(HALF);
        model_load();
        check_eq({tag, "/pulses"}, 32'(n_pulses - p0), 32'd1);
    endtask

    task automatic link_reset(input string tag);
        int p0;
        p0 = n_pulses;
        cfg_clk = 1'b0;
        rst_not = 1'b0;
        wait_cyc(HALF);
        // Edges during link reset must be ignored
        cfg_clk  = 1'b1;
        cfg_load = 1'b1;
        wait_cyc(HALF);
        cfg_clk  = 1'b0;
        cfg_load = 1'b0;
        wait_cyc(HALF);
        model_clear();
        check_state({tag, "/in_rst"});
        rst_not = 1'b1;
        wait_cyc(HALF);
        check_eq({tag, "/no_pulse"}, 32'(n_pulses - p0), 32'd0);
    endtask

    initial begin
        aresetn  = 1'b0;
        cfg_clk  = 1'b0;
        rst_not  = 1'b1;
        cfg_in   = 1'b0;
        cfg_load = 1'b0;
        sp_sel   = 1'b0;
        model_clear();
        wait_cyc(3);
        check_state("reset");
        check_eq("reset/pulse", 32'(load_pulse), 32'd0);
        check_eq("reset/sp_sel", 32'(sp_sel_q), 32'd0);
        aresetn = 1'b1;
        wait_cyc(HALF);

        // Shift-to-count latency is SYNC_STAGES+1 cycles
        cfg_in  = 1'b1;
        wait_cyc(HALF);
        cfg_clk = 1'b1;
        wait_cyc(SS);
        check_eq("lat/before", 32'(bit_count), 32'd0);
        wait_cyc(1);
        check_eq("lat/after", 32'(bit_count), 32'd1);
        model_shift(1'b1);
        link_reset("lat_clr");

        // 0xA5 then load
        send_byte(8'hA5);
        check_state("a5/pre");
        do_load("a5");
        check_state("a5/post");

        // 10 bits 1,1,0... : overflow before load, replay of first bit on ConfigOut
        for (int i = 0; i < 10; i++) begin
            send_bit(i < 2);
            check_state($sformatf("ovf/b%0d", i));
        end
        do_load("ovf");
        check_state("ovf/post");

        // Coincident shift and load after 7 bits
        for (int i = 0; i < 7; i++) send_bit(1'(i & 1));
        cfg_in  = 1'b1;
        cfg_clk = 1'b0;
        wait_cyc(HALF);
        begin
            int p0;
            p0 = n_pulses;
            cfg_clk  = 1'b1;
            cfg_load = 1'b1;
            wait_cyc(HALF);
            cfg_clk  = 1'b0;
            cfg_load = 1'b0;
            wait_cyc(HALF);
            model_shift(1'b1);
            model_load();
            check_eq("coinc/pulses", 32'(n_pulses - p0), 32'd1);
        end
        check_state("coinc");

        // Link reset mid-shift, then 0x3C
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        link_reset("lrst");
        send_byte(8'h3C);
        do_load("3c");
        check_state("3c");

        // Counter saturation
        for (int i = 0; i < 17; i++) send_bit(1'(i % 3 == 0));
        check_state("sat");
        do_load("sat");
        check_state("sat/post");

        // Asynchronous AXI reset mid-shift
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        cfg_clk = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        model_clear();
        check_state("areset/async");
        check_eq("areset/pulse", 32'(load_pulse), 32'd0);
        wait_cyc(2);
        aresetn = 1'b1;
        wait_cyc(HALF);
        send_byte(8'h96);
        do_load("after_areset");
        check_state("after_areset");

        // Randomised traffic
        for (int it = 0; it < 60; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                send_bit(1'($urandom_range(0, 1)));
                cfg_clk = 1'b0;
                wait_cyc(HALF);
            end else if (op <= 7) begin
                do_load($sformatf("rnd%0d", it));
            end else if (op == 8) begin
                link_reset($sformatf("rnd%0d", it));
            end else begin
                logic s;
                s = 1'($urandom_range(0, 1));
                sp_sel = s;
                wait_cyc(SS + 1);
                check_eq($sformatf("rnd%0d/sp_sel", it), 32'(sp_sel_q), 32'(s));
            end
            check_state($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
